data_mem_unit: RTL
==================

# data_mem_unit

Parametrised, clocked data memory for the MEM stage of the five-stage MIPS pipeline. Replaces the combinational word-only memory with:
- a synchronous byte-enabled write port;
- a registered sized-load port (byte/half/word, sign or zero extension);
- a power-up clear sequencer;
- an optional misalignment check.

It sits between the EX/MEM pipeline register and the MEM/WB register.

## Interface
- DEPTH, 128, number of 32-bit words; power of two, ≥ 4
- ADDR_W, $clog2(DEPTH)+2, byte-address width (derived; not overridden)
- Clk  input  1  clock; all state updates on rising edge
- Rst_n  input  1  reset, synchronous, active-low
- MemRead  input  1  load request this cycle
- MemWrite  input  1  store request this cycle
- Size  input  2  00 byte, 01 half, 10 word, 11 reserved
- Unsigned  input  1  1 = zero-extend loads, 0 = sign-extend
- Address  input  ADDR_W  byte address
- WriteData  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- ReadData  output  32  extended load result, registered
- ReadValid  output  1  ReadData updated by the load sampled on the previous edge
- Busy  output  1  clear sequence in progress; requests ignored
- AddrErr  output  1  one-cycle pulse: previous request was illegal

## Operation
- Memory is little-endian: byte offset k of a word occupies bits [8k+7:8k].
- Word index = Address[ADDR_W-1:2]; lane offset = Address[1:0].
- FSM states:
  - CLEAR: writes zero to word CNT each cycle; CNT increments; after word DEPTH-1 is written, moves to READY.
  - READY: services requests.
- Rst_n low → state CLEAR, CNT 0.
- Store in READY (MemWrite=1): byte enables from Size and offset.
  - Byte: writes WriteData[7:0] to lane offset.
  - Half: writes WriteData[15:0] to lanes offset, offset+1.
  - Word: writes all four lanes.
  - Unwritten lanes keep their value.
- Load in READY (MemRead=1, MemWrite=0): selects lane(s) at the offset and extends to 32 bits per Unsigned. Registers ReadData and sets ReadValid=1 for one cycle.
- MemRead and MemWrite both high: the store executes, the load is dropped, ReadValid=0.
- No request: ReadData holds its value, ReadValid=0.
- Size=11 is always illegal: no write, no ReadValid, AddrErr pulses.
- Requests while Busy: no write, no ReadValid, no AddrErr.

## Timing
- Reset values: ReadData 0, ReadValid 0, AddrErr 0, Busy 1.
- Busy stays 1 for exactly DEPTH cycles after the first edge with Rst_n high. First request accepted on the edge after Busy falls.
- Rst_n low during CLEAR restarts the clear from word 0. Rst_n low during READY aborts any request on that edge.
- Load latency is 1 cycle: request sampled at edge N; ReadData/ReadValid valid from edge N until edge N+1.
- A store sampled at edge N is visible to a load sampled at edge N+1.
- A load and a store to the same word on the same edge are impossible (store wins; see above).
- AddrErr is asserted for the cycle following the offending request edge.

## Configuration
- DMEM_ALIGN_CHECK_EN defined:
  - Half with Address[0]=1, or word with Address[1:0]≠00, is illegal.
  - An illegal request performs no write and no ReadValid; AddrErr pulses.
- Undefined:
  - Misaligned low address bits are forced to alignment (half ignores bit 0, word ignores bits 1:0) and the access proceeds.
  - AddrErr pulses only for Size=11.

## Structure
- Shared package dmem_pkg holds:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD.
  - FSM state typedef: ST_CLEAR, ST_READY.
- One natural sub-module: load_align_ext, a combinational lane select plus sign/zero extension (word, offset, Size, Unsigned → 32-bit result), reused by later load paths.
- Storage: DEPTH×32 array written per byte lane, with a registered read path.

## Test plan
- Clear sequence: Rst_n low 2 cycles, then high.
  - Busy is high for exactly 128 cycles.
  - A word load of address 0x1FC issued on the edge after Busy falls returns 0x00000000.
- Byte stores and sized loads:
  - Store 0x11, 0x22, 0x33, 0x84 to addresses 0x40–0x43 (byte).
  - Word load of 0x40 → 0x84332211.
  - Signed byte load of 0x43 → 0xFFFFFF84.
  - Unsigned byte load of 0x43 → 0x00000084.
  - Signed half load of 0x42 → 0xFFFF8433.
- Partial write preserves other lanes:
  - Word store 0xDEADBEEF to 0x10, then half store 0x1234 to 0x12.
  - Word load of 0x10 → 0x1234BEEF.
- Back-to-back timing:
  - Store 0xCAFEF00D to 0x20 at edge N, word load of 0x20 at edge N+1 → ReadData 0xCAFEF00D, ReadValid=1 after edge N+1.
  - Simultaneous MemRead and MemWrite → ReadValid=0 and the store is performed.
- Misaligned access:
  - With DMEM_ALIGN_CHECK_EN, word store to 0x22: AddrErr pulses one cycle and memory is unchanged.
  - Without the macro, the same store writes word 0x20.
  - Size=11 always gives an AddrErr pulse with no write.
- Reset mid-operation:
  - Rst_n low at clear cycle 50 → Busy stays high for 128 further cycles.
  - Rst_n low in READY → ReadValid=0 and ReadData=0 on the following cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data memory: access-size encodings,
// sequencer states and the byte-lane helpers used by the store path.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Little-endian lane enables; half and word ignore the low offset bits,
  // which is what gives the forced-alignment behaviour when no check is built.
  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] offset);
    case (size_e'(size))
      SZ_BYTE: lane_enables = 4'b0001 << offset;
      SZ_HALF: lane_enables = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_enables = 4'b1111;
      default: lane_enables = 4'b0000;
    endcase
  endfunction

  // Replicate right-justified store data across lanes so the enables pick it.
  function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                            input logic [31:0] wdata);
    case (size_e'(size))
      SZ_BYTE: lane_data = {4{wdata[7:0]}};
      SZ_HALF: lane_data = {2{wdata[15:0]}};
      default: lane_data = wdata;
    endcase
  endfunction

  function automatic logic is_aligned(input logic [1:0] size,
                                      input logic [1:0] offset);
    case (size_e'(size))
      SZ_HALF: is_aligned = ~offset[0];
      SZ_WORD: is_aligned = (offset == 2'b00);
      default: is_aligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load lane select plus sign/zero extension of a 32-bit
// little-endian memory word to a right-justified 32-bit result.
module load_align_ext
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every signal written in always_comb gets a value on every path
  // (defaults first), otherwise synthesis infers a latch.
  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    result_o = word_i;
    case (size_e'(size_i))
      SZ_BYTE: result_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      SZ_HALF: result_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      default: result_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data memory: byte-enabled synchronous store, registered sized load,
// power-up clear sequencer. Define DMEM_ALIGN_CHECK_EN to reject misaligned
// half/word accesses instead of forcing them to alignment.
module data_mem_unit
  import dmem_pkg::*;
#(
  parameter  int DEPTH  = 128,
  localparam int ADDR_W = $clog2(DEPTH) + 2
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  input  logic [ADDR_W-1:0] Address,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              ReadValid,
  output logic              Busy,
  output logic              AddrErr
);

  localparam int IDX_W = ADDR_W - 2;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;
  logic             addr_err_q, addr_err_d;

  logic [31:0]      mem_q [DEPTH];

  logic [IDX_W-1:0] word_idx;
  logic [1:0]       offset;
  logic             req;
  logic             legal;
  logic [31:0]      rd_word;
  logic [31:0]      load_result;

  logic             mem_we;
  logic [IDX_W-1:0] mem_idx;
  logic [3:0]       mem_be;
  logic [31:0]      mem_wdata;

  assign word_idx = Address[ADDR_W-1:2];
  assign offset   = Address[1:0];
  assign req      = MemRead | MemWrite;
  assign rd_word  = mem_q[word_idx];

`ifdef DMEM_ALIGN_CHECK_EN
  assign legal = (size_e'(Size) != SZ_RSVD) && is_aligned(Size, offset);
`else
  assign legal = (size_e'(Size) != SZ_RSVD);
`endif

  load_align_ext u_load_align_ext (
    .word_i     (rd_word),
    .offset_i   (offset),
    .size_i     (Size),
    .unsigned_i (Unsigned),
    .result_o   (load_result)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    mem_idx    = word_idx;
    mem_be     = lane_enables(Size, offset);
    mem_wdata  = lane_data(Size, WriteData);

    case (state_q)
      ST_CLEAR: begin
        // Requests are ignored entirely while clearing: no write, no error.
        mem_we    = 1'b1;
        mem_idx   = cnt_q;
        mem_be    = 4'b1111;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (req && !legal) begin
          addr_err_d = 1'b1;
        end else if (MemWrite) begin
          mem_we = 1'b1;
        end else if (MemRead) begin
          rvalid_d = 1'b1;
          rdata_d  = load_result;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; reset here is synchronous to Clk.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      addr_err_q <= addr_err_d;
    end
  end

  // NOTE: the storage array has no reset term; the clear sequencer zeroes it,
  // which keeps it mappable onto RAM macros.
  always_ff @(posedge Clk) begin
    if (Rst_n && mem_we) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (mem_be[lane]) begin
          mem_q[mem_idx][lane*8 +: 8] <= mem_wdata[lane*8 +: 8];
        end
      end
    end
  end

  assign ReadData  = rdata_q;
  assign ReadValid = rvalid_q;
  assign AddrErr   = addr_err_q;
  assign Busy      = (state_q == ST_CLEAR);

endmodule
